// File: rtl/aes_key_scheduler.sv
// AES-128 key expansion: one schedule word per clock, w[4]..w[43].
// Optional last-key cache enabled by defining KS_KEY_CACHE_EN.
module aes_key_scheduler #(
    parameter int DONE_PULSE = 0
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          start,
    input  logic [127:0]  Cipherkey,
    input  logic [3:0]    round_sel,
    output logic [1407:0] KeySchedule,
    output logic [127:0]  round_key,
    output logic          busy,
    output logic          done,
    output logic          ks_valid
);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    state_t      state;
    state_t      next_state;
    logic [31:0] w [44];
    logic [5:0]  i;
    logic [7:0]  rcon;
    logic        armed;
    logic        hit_q;
    logic        hit;
    logic        accept;
    logic        finish;
    logic [31:0] prev;
    logic [31:0] rot;
    logic [31:0] sub;
    logic [31:0] temp;
    logic [31:0] new_word;
    logic [10:0] sel_hi;

    for (genvar g = 0; g < 44; g++) begin : g_pack
        assign KeySchedule[1407-32*g -: 32] = w[g];
    end

    assign busy = (state == S_EXPAND);

    always_comb begin
        prev     = w[i - 6'd1];
        rot      = {prev[23:0], prev[31:24]};
        sub      = {SBOX[rot[31:24]], SBOX[rot[23:16]],
                    SBOX[rot[15:8]],  SBOX[rot[7:0]]};
        temp     = (i[1:0] == 2'd0) ? (sub ^ {rcon, 24'h0}) : prev;
        new_word = w[i - 6'd4] ^ temp;
    end

    always_comb begin
        sel_hi    = 11'd1407 - {round_sel, 7'd0};
        round_key = '0;
        if (round_sel <= 4'd10)
            round_key = KeySchedule[sel_hi -: 128];
    end

    // A start is accepted one cycle before EXPAND; the armed cycle is not busy.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        finish     = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (armed) begin
                    if (hit_q) begin
                        next_state = S_DONE;
                        finish     = 1'b1;
                    end else begin
                        next_state = S_EXPAND;
                    end
                end else if (start) begin
                    accept = 1'b1;
                end
            end
            S_EXPAND: begin
                if (i == 6'd43) begin
                    next_state = S_DONE;
                    finish     = 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 44; k++)
                w[k] <= '0;
            i        <= '0;
            rcon     <= 8'h01;
            done     <= 1'b0;
            ks_valid <= 1'b0;
            armed    <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            armed <= accept;
            hit_q <= accept & hit;
            if (accept && !hit) begin
                w[0] <= Cipherkey[127:96];
                w[1] <= Cipherkey[95:64];
                w[2] <= Cipherkey[63:32];
                w[3] <= Cipherkey[31:0];
                i    <= 6'd4;
                rcon <= 8'h01;
            end
            if (state == S_EXPAND) begin
                w[i] <= new_word;
                i    <= i + 6'd1;
                if (i[1:0] == 2'd0)
                    rcon <= xtime(rcon);
            end
            if (finish) begin
                done     <= 1'b1;
                ks_valid <= 1'b1;
            end else if (accept) begin
                done     <= 1'b0;
                ks_valid <= 1'b0;
            end else if (DONE_PULSE != 0) begin
                done <= 1'b0;
            end
        end
    end

`ifdef KS_KEY_CACHE_EN
    logic [127:0] cache_key;
    logic         cache_valid;

    assign hit = cache_valid && (Cipherkey == cache_key);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cache_key   <= '0;
            cache_valid <= 1'b0;
        end else if (accept && !hit) begin
            cache_valid <= 1'b0;
        end else if (finish) begin
            cache_key   <= {w[0], w[1], w[2], w[3]};
            cache_valid <= 1'b1;
        end
    end
`else
    assign hit = 1'b0;
`endif

endmodule

// File: doc/aes_key_scheduler.md
Name: aes_key_scheduler

Overview:
Sequential AES-128 key expansion engine that sits directly upstream of the inverse-cipher controller. On a start request it loads the 128-bit cipher key and produces one 32-bit schedule word per clock, w[4]..w[43]. It presents the full 1408-bit schedule plus a random-access round-key read port. The decryption controller consumes the round keys in reverse order (round 10 down to round 0) once done is high.

Parameters:
DONE_PULSE, 0, 0 = done is a level held until the next start; 1 = done is a single-cycle pulse while ks_valid holds the level.

Ports:
clk  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-high; clears all state
start  in  1  request expansion of Cipherkey; sampled only in IDLE or DONE
Cipherkey  in  128  AES-128 key, byte 0 in bits [127:120]
round_sel  in  4  round index 0..10 for round_key
KeySchedule  out  1408  w[0] in bits [1407:1376] … w[43] in bits [31:0]; round r key = w[4r..4r+3]
round_key  out  128  combinational slice of KeySchedule for round_sel; 0 when round_sel > 10
busy  out  1  high while expanding
done  out  1  completion indication (see DONE_PULSE)
ks_valid  out  1  schedule complete and consistent with the last accepted key

Behaviour:
- Reset values: state = IDLE; KeySchedule = 0; busy, done and ks_valid = 0; word index i = 0; rcon = 8'h01.
- States are IDLE, EXPAND and DONE.
- IDLE or DONE with start=1:
  - latch Cipherkey into w[0..3];
  - clear ks_valid and done;
  - set i = 4, rcon = 01;
  - go to EXPAND.
- start=0 in IDLE/DONE: hold state.
- EXPAND, one word per cycle:
  - temp = w[i-1];
  - if i mod 4 == 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then advance rcon = xtime(rcon) (01,02,04,…,80,1B,36);
  - w[i] = w[i-4] ^ temp; i++.
  - After writing w[43], go to DONE.
- SubWord: four forward S-box lookups, combinational, inside the block. xtime = {r[6:0],1'b0} ^ (r[7] ? 8'h1B : 0).
- busy = 1 exactly in EXPAND.
- Latency:
  - start sampled at edge N → EXPAND from N+1;
  - w[43] written at edge N+41 → done and ks_valid high after N+41.
  - Total is 41 cycles.
- start during EXPAND is ignored; the current expansion completes with the originally latched key.
- Cipherkey changes after the start edge do not affect the result.
- DONE_PULSE=0: done stays high in DONE until the next accepted start. DONE_PULSE=1: done is high for one cycle after N+41.
- ks_valid stays high in DONE and clears on the accepted start.
- Words w[4..43] are not cleared on restart. They are overwritten progressively; consumers must gate on ks_valid.
- Reset asserted mid-EXPAND: immediate return to IDLE with KeySchedule zeroed. No partial done.
- round_key is purely combinational from KeySchedule and round_sel, valid the same cycle.

Optional Feature:
Macro KS_KEY_CACHE_EN.
- Defined:
  - the block keeps a 128-bit copy of the last fully expanded key plus a cache-valid flag (cleared on Reset and at the start of any expansion, set on completion);
  - a start in IDLE/DONE whose Cipherkey equals the cached key while cache-valid=1 goes straight to DONE on the next edge without touching KeySchedule;
  - in that case done/ks_valid are high 1 cycle after start and busy stays 0.
- Not defined: every start performs the full 41-cycle expansion; no key copy is kept.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse → done after exactly 41 cycles; round_sel=1 gives a0fafe1788542cb123a339392a6c7605; round_sel=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6; round_sel=0 gives the key itself; round_sel=11 gives 0.
- Key 000102030405060708090a0b0c0d0e0f → round 10 key 13111d7fe3944a17f307a78b4d2b30c5; all 1408 bits match the reference model.
- Start the first key, pulse start again with a different key at cycle 20 → ignored; result equals the first-key schedule and busy was high for 40 cycles.
- Assert Reset at cycle 15 of expansion → next cycle KeySchedule=0, busy=done=ks_valid=0; a fresh start then completes normally in 41 cycles.
- DONE_PULSE=1 → done high for exactly one cycle while ks_valid stays high; a second start from DONE re-expands and drops ks_valid on the start edge.
- KS_KEY_CACHE_EN defined: repeat start with the same key → done 1 cycle later, busy never high; different key → full 41-cycle run.
